// File: rtl/rv_lsu.sv
// Load/store unit: turns decoded load/store requests into a single word-wide
// request/acknowledge data-memory transaction and returns a one-cycle response
// carrying the aligned, extended load data or an error flag.
module rv_lsu #(
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [2:0]    mem_op,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          rsp_valid,
  output logic [31:0]   rdata,
  output logic          err,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [3:0]    dmem_be,
  output logic [31:0]   dmem_wdata,
  input  logic          dmem_ack,
  input  logic [31:0]   dmem_rdata
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e        state_q, state_d;
  logic          accept;

  logic          req_err;
  logic [3:0]    req_be;
  logic [31:0]   req_wdata;

  logic [1:0]    off_q;
  logic [2:0]    op_q;
  logic          we_q;
  logic          err_q;
  logic [AW-1:0] addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;

  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   load_data;

  // Decode the incoming request: byte enables, lane-replicated store data, errors.
  always_comb begin
    req_err   = 1'b0;
    req_be    = 4'b0000;
    req_wdata = 32'h0;
    case (mem_op)
      3'b000, 3'b100: begin
        req_be    = 4'b0001 << addr[1:0];
        req_wdata = {4{wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        req_be    = addr[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{wdata[15:0]}};
        req_err   = addr[0];
      end
      3'b010: begin
        req_be    = 4'b1111;
        req_wdata = wdata;
        req_err   = (addr[1:0] != 2'b00);
      end
      default: req_err = 1'b1;
    endcase
    // Unsigned formats only make sense for loads.
    if (mem_write && mem_op[2]) req_err = 1'b1;
    if (mem_read && mem_write) req_err = 1'b1;
  end

  // Next-state logic; errored requests skip the bus and respond straight away.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid && (mem_read || mem_write)) begin
          accept  = 1'b1;
          state_d = req_err ? StResp : StBus;
        end
      end
      StBus:   if (dmem_ack) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Select the addressed lane of the returned word and extend it.
  always_comb begin
    lane_b = 8'h0;
    case (off_q)
      2'd0:    lane_b = dmem_rdata[7:0];
      2'd1:    lane_b = dmem_rdata[15:8];
      2'd2:    lane_b = dmem_rdata[23:16];
      default: lane_b = dmem_rdata[31:24];
    endcase
    lane_h    = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_data = 32'h0;
    case (op_q)
      3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_data = {24'h0, lane_b};
      3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_data = {16'h0, lane_h};
      3'b010:  load_data = dmem_rdata;
      default: load_data = 32'h0;
    endcase
  end

  // State register plus request capture and load-data capture on the ack edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      off_q   <= 2'b00;
      op_q    <= 3'b000;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        off_q   <= addr[1:0];
        op_q    <= mem_op;
        we_q    <= mem_write;
        err_q   <= req_err;
        addr_q  <= {addr[AW-1:2], 2'b00};
        be_q    <= req_be;
        wdata_q <= req_wdata;
        rdata_q <= 32'h0;
      end
      if (state_q == StBus && dmem_ack) begin
        rdata_q <= we_q ? 32'h0 : load_data;
      end
    end
  end

  // Outputs decode from the state register; bus fields are zero outside BUS.
  always_comb begin
    req_ready  = (state_q == StIdle);
    rsp_valid  = (state_q == StResp);
    err        = rsp_valid & err_q;
    rdata      = rsp_valid ? rdata_q : 32'h0;
    dmem_req   = (state_q == StBus);
    dmem_we    = dmem_req & we_q;
    dmem_addr  = dmem_req ? addr_q : '0;
    dmem_be    = dmem_req ? be_q : 4'b0000;
    dmem_wdata = dmem_req ? wdata_q : 32'h0;
  end

endmodule
